// File: rtl/mem_responder.sv
// Single-port word memory behind a request/response handshake.
// One transaction at a time: accept in IDLE, wait LAT edges in BUSY,
// present a one-cycle response in RESP. Misaligned or out-of-range
// byte addresses complete with rsp_err=1 and never touch memory.
module mem_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LAT        = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int         DEPTH    = 2 ** DEPTH_LOG2;
    // Counter preload: BUSY lasts LAT edges, the last one being the edge seen with count 0.
    localparam logic [3:0] LAT_LOAD = 4'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        commit;

    // Request fields frozen at acceptance; inputs are ignored afterwards.
    logic        we_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;

    logic [31:0] rdata_reg;
    logic        err_reg;

    logic [31:0] mem [DEPTH];

    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  cap_err;

    // Address decode of the captured request: word index plus the two fault conditions.
    always_comb begin
        word_idx     = addr_reg[DEPTH_LOG2+1:2];
        misaligned   = (addr_reg[1:0] != 2'b00);
        out_of_range = ((addr_reg >> (DEPTH_LOG2 + 2)) != 32'd0);
        cap_err      = misaligned || out_of_range;
    end

    // Next-state, latency counter and handshake outputs.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        commit     = 1'b0;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = BUSY;
                    cnt_next   = LAT_LOAD;
                end
            end
            BUSY: begin
                if (cnt_reg == 4'd0) begin
                    state_next = RESP;
                    commit     = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP: begin
                rsp_valid  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // State and counter registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Capture the request on the acceptance edge.
    always_ff @(posedge clk) begin
        if (!rst && state_reg == IDLE && req_valid) begin
            we_reg    <= req_we;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
        end
    end

    // Memory write on the BUSY->RESP edge; faulting writes and reset edges leave it untouched.
    always_ff @(posedge clk) begin
        if (!rst && commit && we_reg && !cap_err) begin
            mem[word_idx] <= wdata_reg;
        end
    end

    // Registered response: read data sampled on the BUSY->RESP edge, held until the next response.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_reg <= 32'd0;
            err_reg   <= 1'b0;
        end else if (commit) begin
            err_reg   <= cap_err;
            rdata_reg <= (cap_err || we_reg) ? 32'd0 : mem[word_idx];
        end
    end

    assign rsp_rdata = rdata_reg;
    assign rsp_err   = err_reg;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 8: memory holds 2**DEPTH_LOG2 32-bit words.
REQ-002 SHALL have parameter LAT, default 2: access latency in clock edges, legal range 1..15.
REQ-003 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  requester presents a transaction.
REQ-006 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_wdata  input  32  write data.
REQ-009 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata  output  32  read data, qualified by rsp_valid.
REQ-012 SHALL have port rsp_err  output  1  access fault, qualified by rsp_valid.

Function
REQ-013 SHALL implement a registered FSM with states IDLE, BUSY and RESP.
REQ-014 SHALL drive req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-015 SHALL accept a request on an edge where state=IDLE and req_valid=1, capturing req_we, req_addr and req_wdata.
REQ-016 SHALL, on acceptance, load a 4-bit latency counter with LAT-1 and enter BUSY.
REQ-017 SHALL ignore req_* inputs in BUSY and RESP; the captured values are used, and input changes have no effect.
REQ-018 SHALL, in BUSY, decrement the counter each edge while it is nonzero and go to RESP on the edge where it is 0.
REQ-019 SHALL assert rsp_valid for exactly one cycle, beginning LAT edges after the acceptance edge, then return to IDLE.
REQ-020 SHALL make back-to-back throughput one transaction per LAT+2 cycles; there is no pipelining and no overlap.
REQ-021 SHALL flag an error when the captured addr[1:0] != 0 (misaligned).
REQ-022 SHALL flag an error when captured addr[31:DEPTH_LOG2+2] != 0 (out of range).
REQ-023 SHALL index memory with the word index addr[DEPTH_LOG2+1:2].
REQ-024 SHALL commit a non-error write on the BUSY->RESP edge; an error write leaves memory unchanged.
REQ-025 SHALL capture read data into rsp_rdata on the BUSY->RESP edge.
REQ-026 SHALL return rsp_rdata=0 for writes and for error transactions.
REQ-027 SHALL make a read issued after a completed write to the same word return the written data.
REQ-028 SHALL make word 2**DEPTH_LOG2-1 (byte address 4*2**DEPTH_LOG2-4) fully accessible; the next word address faults rather than wrapping to 0.
REQ-029 SHALL hold rsp_rdata and rsp_err outside RESP at their last value; consumers sample them only with rsp_valid.

Reset
REQ-030 SHALL give rst priority over all other activity on the same edge.
REQ-031 SHALL, on rst, set state=IDLE, counter=0, rsp_valid=0, rsp_err=0 and rsp_rdata=0, so req_ready=1 the cycle after reset.
REQ-032 SHALL, on rst in BUSY, abandon the transaction: no write is committed and no rsp_valid is produced.
REQ-033 SHALL leave memory contents unaffected by rst; contents are zero-initialised at simulation start.

Verification
REQ-034 SHALL cover (LAT=2) write 0xDEADBEEF @0x10, then read 0x10 -> read rsp_rdata=0xDEADBEEF, rsp_err=0; each rsp_valid 2 edges after acceptance; req_ready low 3 cycles per transaction.
REQ-035 SHALL cover read @0x13 -> rsp_err=1, rsp_rdata=0; write 0xFFFFFFFF @0x22, then read 0x20 -> prior value of word 0x20 unchanged.
REQ-036 SHALL cover write 0xA5A5A5A5 @0x3FC, then read 0x3FC -> 0xA5A5A5A5; read @0x400 -> rsp_err=1; word 0 unchanged.
REQ-037 SHALL cover write 0x12345678 @0x40, rst asserted during the first BUSY cycle -> no rsp_valid, req_ready=1 next cycle, read 0x40 returns prior value.
REQ-038 SHALL cover req_valid held high with 4 queued reads and req_addr changed mid-BUSY -> exactly 4 rsp_valid pulses 4 cycles apart, each returning data for the address captured at acceptance.
REQ-039 SHALL cover LAT=1 with write 0x1 @0x8 -> rsp_valid 1 edge after acceptance; req_ready low 2 cycles.
